// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_pkg
//  Description : Shared types and helpers for the reset/start sequencer.
//                Provides the FSM state encoding, the control-group indices
//                and constant functions for each group's width and bit offset
//                inside the concatenated seq_n bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'd0,
        GAP1 = 3'd1,
        CAPT = 3'd2,
        GAP2 = 3'd3,
        DONE = 3'd4
    } seq_state_e;

    // Group order on the bus, lowest offset first.
    localparam int unsigned GRP_RESET    = 0;
    localparam int unsigned GRP_START    = 1;
    localparam int unsigned GRP_STEP     = 2;
    localparam int unsigned GRP_DELAY    = 3;
    localparam int unsigned GRP_CAPTURE  = 4;
    localparam int unsigned GRP_CUTSCAN  = 5;
    localparam int unsigned GRP_PASSTHRU = 6;
    localparam int unsigned GRP_INJECT   = 7;
    localparam int unsigned NUM_GRPS     = 8;

    // Width of one group, selected by index.
    function automatic int unsigned grp_width(
        input int unsigned grp,
        input int unsigned w0, input int unsigned w1,
        input int unsigned w2, input int unsigned w3,
        input int unsigned w4, input int unsigned w5,
        input int unsigned w6, input int unsigned w7
    );
        case (grp)
            0:       grp_width = w0;
            1:       grp_width = w1;
            2:       grp_width = w2;
            3:       grp_width = w3;
            4:       grp_width = w4;
            5:       grp_width = w5;
            6:       grp_width = w6;
            default: grp_width = w7;
        endcase
    endfunction

    // Begin offset of a group: sum of the widths of all groups below it.
    function automatic int unsigned grp_base(
        input int unsigned grp,
        input int unsigned w0, input int unsigned w1,
        input int unsigned w2, input int unsigned w3,
        input int unsigned w4, input int unsigned w5,
        input int unsigned w6, input int unsigned w7
    );
        grp_base = 0;
        if (grp > 0) grp_base += w0;
        if (grp > 1) grp_base += w1;
        if (grp > 2) grp_base += w2;
        if (grp > 3) grp_base += w3;
        if (grp > 4) grp_base += w4;
        if (grp > 5) grp_base += w5;
        if (grp > 6) grp_base += w6;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_dur_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_dur_counter
//  Description : Loadable saturating down-counter for sequence stage timing.
//                A load value of zero is clamped to one. The count stops at
//                zero and never wraps. o_expire flags the last cycle of a
//                stage (count == 1).
//  Ports       : clk, reset_n (sync, active-low, clears the count)
//                i_load / i_load_val  - load request and duration
//                o_count              - current count
//                o_expire             - count has reached 1
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_dur_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= (i_load_val == '0) ? CNT_W'(1) : i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_expire = (r_count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_ctrl
//  Description : Clocked reset/start sequencer driving a bus of active-low
//                control groups (RESET, START, STEP, DELAY, CAPTURE, CUTSCAN,
//                PASSTHRU, INJECT). Stage lengths are programmable in cycles
//                and the sequence can be re-run with restart.
//  Ports       : clk, reset_n (sync, active-low)
//                restart      - re-run the sequence from HOLD
//                dly_val      - level for DELAY bits, latched at start
//                reset_cycles - HOLD length, latched at start
//                start_cycles - gap stage length, latched at start
//                step_req     - STEP pulse request (pulse build only)
//                seq_n        - control bus, RESET group at bit 0
//                seq_state    - current FSM state
//                seq_done     - high while in DONE
//  Build macro : RESET_SEQ_CTRL_STEP_PULSE_EN - STEP bits become one-cycle
//                pulses requested by step_req while in DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int RESETS    = 1,
    parameter int STARTS    = 0,
    parameter int STEPS     = 0,
    parameter int DELAYS    = 0,
    parameter int CAPTURES  = 0,
    parameter int CUTSCANS  = 0,
    parameter int PASSTHRUS = 0,
    parameter int INJECTS   = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             restart,
    input  logic             dly_val,
    input  logic [CNT_W-1:0] reset_cycles,
    input  logic [CNT_W-1:0] start_cycles,
    input  logic             step_req,
    output logic [RESETS+STARTS+STEPS+DELAYS+CAPTURES+CUTSCANS+PASSTHRUS+INJECTS-1:0] seq_n,
    output logic [2:0]       seq_state,
    output logic             seq_done
);

    localparam int N = RESETS + STARTS + STEPS + DELAYS + CAPTURES + CUTSCANS + PASSTHRUS + INJECTS;

    localparam logic [2:0] c_ST_HOLD = HOLD;
    localparam logic [2:0] c_ST_GAP1 = GAP1;
    localparam logic [2:0] c_ST_CAPT = CAPT;
    localparam logic [2:0] c_ST_GAP2 = GAP2;
    localparam logic [2:0] c_ST_DONE = DONE;

    localparam bit c_HAS_GAP1 = (STARTS + STEPS + CAPTURES) > 0;
    localparam bit c_HAS_CAPT = CAPTURES > 0;
    localparam bit c_HAS_GAP2 = (STARTS + STEPS) > 0;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_reset_dur;
    logic [CNT_W-1:0] r_start_dur;
    logic             r_dly;
    logic [N-1:0]     r_seq_n;
    logic             r_done;

    logic [2:0]       w_state_nxt;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_expire;
    logic             w_dly_nxt;
    logic             w_step_lvl;
    logic [NUM_GRPS-1:0] w_grp_val;
    logic [N-1:0]     w_seq_nxt;
    logic             w_unused;

    seq_dur_counter #(
        .CNT_W (CNT_W)
    ) u_dur_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_count    (w_cnt),
        .o_expire   (w_cnt_expire)
    );

    // Next-state and counter-load logic. The CAPT cycle is the first cycle
    // of the second gap: the gap length is loaded on CAPT entry, so
    // CAPT + GAP2 together span max(start_cycles,1) cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = r_start_dur;
        if (restart) begin
            // Restart reloads straight from the inputs, same edge.
            w_state_nxt = c_ST_HOLD;
            w_cnt_load  = 1'b1;
            w_cnt_val   = reset_cycles;
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    if (w_cnt == '0) begin
                        // Zero count in HOLD only occurs right after reset:
                        // first cycle with reset_n high arms the HOLD count.
                        w_cnt_load = 1'b1;
                        w_cnt_val  = r_reset_dur;
                    end else if (w_cnt_expire) begin
                        if (c_HAS_GAP1) begin
                            w_state_nxt = c_ST_GAP1;
                            w_cnt_load  = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_DONE;
                        end
                    end
                end
                c_ST_GAP1: begin
                    if (w_cnt_expire) begin
                        if (c_HAS_CAPT) begin
                            w_state_nxt = c_ST_CAPT;
                            w_cnt_load  = 1'b1;
                        end else begin
                            w_state_nxt = c_ST_DONE;
                        end
                    end
                end
                c_ST_CAPT: begin
                    if (!c_HAS_GAP2 || w_cnt_expire) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_state_nxt = c_ST_GAP2;
                    end
                end
                c_ST_GAP2: begin
                    if (w_cnt_expire) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    w_state_nxt = c_ST_DONE;
                end
                default: begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = r_reset_dur;
                end
            endcase
        end
    end

    assign w_dly_nxt = restart ? dly_val : r_dly;

`ifdef RESET_SEQ_CTRL_STEP_PULSE_EN
    // A request seen while already in DONE yields STEP on the next cycle,
    // unless the same edge leaves DONE.
    assign w_step_lvl = step_req && (r_state == c_ST_DONE) && (w_state_nxt == c_ST_DONE);
`else
    assign w_step_lvl = (w_state_nxt == c_ST_DONE);
`endif

    // Per-group level for the coming cycle; outputs are registered from the
    // next state so they change on the same edge as the state.
    always_comb begin
        w_grp_val               = '0;
        w_grp_val[GRP_RESET]    = (w_state_nxt != c_ST_HOLD);
        w_grp_val[GRP_START]    = (w_state_nxt == c_ST_DONE);
        w_grp_val[GRP_STEP]     = w_step_lvl;
        w_grp_val[GRP_DELAY]    = w_dly_nxt;
        w_grp_val[GRP_CAPTURE]  = (w_state_nxt == c_ST_CAPT) ||
                                  (w_state_nxt == c_ST_GAP2) ||
                                  (w_state_nxt == c_ST_DONE);
        w_grp_val[GRP_CUTSCAN]  = 1'b0;
        w_grp_val[GRP_PASSTHRU] = 1'b1;
        w_grp_val[GRP_INJECT]   = 1'b0;
    end

    // Zero-width groups drop their level, and step_req is idle in the
    // level-STEP build; collect them here so they are visibly intentional.
    assign w_unused = ^{w_grp_val, step_req};

    for (genvar g = 0; g < NUM_GRPS; g++) begin : g_grp
        localparam int unsigned c_W = grp_width(g, RESETS, STARTS, STEPS, DELAYS,
                                                CAPTURES, CUTSCANS, PASSTHRUS, INJECTS);
        localparam int unsigned c_B = grp_base(g, RESETS, STARTS, STEPS, DELAYS,
                                               CAPTURES, CUTSCANS, PASSTHRUS, INJECTS);
        if (c_W > 0) begin : g_drive
            assign w_seq_nxt[c_B +: c_W] = {c_W{w_grp_val[g]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= c_ST_HOLD;
            r_reset_dur <= reset_cycles;
            r_start_dur <= start_cycles;
            r_dly       <= dly_val;
            r_seq_n     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (restart) begin
                r_reset_dur <= reset_cycles;
                r_start_dur <= start_cycles;
            end
            r_dly   <= w_dly_nxt;
            r_seq_n <= w_seq_nxt;
            r_done  <= (w_state_nxt == c_ST_DONE);
        end
    end

    assign seq_n     = r_seq_n;
    assign seq_state = r_state;
    assign seq_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_seq_ctrl
//  Description : Directed self-checking bench for reset_seq_ctrl. Five
//                instances cover the default build, a full multi-group
//                sequence, DELAY latching, zero durations and STEP behaviour.
//                Expected values are queued as stimulus is applied and
//                compared after the following clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_seq_ctrl;

`ifdef RESET_SEQ_CTRL_STEP_PULSE_EN
    localparam bit c_PULSE = 1'b1;
`else
    localparam bit c_PULSE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus: index 0..4 = instances a..e
    logic [4:0] rn;
    logic [4:0] rs;
    logic [4:0] dv;
    logic [4:0] sr;
    logic [7:0] rc [5];
    logic [7:0] sc [5];

    logic [0:0] seq_a;  logic [2:0] st_a;  logic done_a;
    logic [4:0] seq_b;  logic [2:0] st_b;  logic done_b;
    logic [4:0] seq_c;  logic [2:0] st_c;  logic done_c;
    logic [1:0] seq_d;  logic [2:0] st_d;  logic done_d;
    logic [1:0] seq_e;  logic [2:0] st_e;  logic done_e;

    // a: defaults (RESET only)
    reset_seq_ctrl u_a (
        .clk(clk), .reset_n(rn[0]), .restart(rs[0]), .dly_val(dv[0]),
        .reset_cycles(rc[0]), .start_cycles(sc[0]), .step_req(sr[0]),
        .seq_n(seq_a), .seq_state(st_a), .seq_done(done_a));

    // b: RESET[1:0] START[2] CAPTURE[3] PASSTHRU[4]
    reset_seq_ctrl #(.RESETS(2), .STARTS(1), .CAPTURES(1), .PASSTHRUS(1)) u_b (
        .clk(clk), .reset_n(rn[1]), .restart(rs[1]), .dly_val(dv[1]),
        .reset_cycles(rc[1]), .start_cycles(sc[1]), .step_req(sr[1]),
        .seq_n(seq_b), .seq_state(st_b), .seq_done(done_b));

    // c: RESET[0] DELAY[4:1]
    reset_seq_ctrl #(.DELAYS(4)) u_c (
        .clk(clk), .reset_n(rn[2]), .restart(rs[2]), .dly_val(dv[2]),
        .reset_cycles(rc[2]), .start_cycles(sc[2]), .step_req(sr[2]),
        .seq_n(seq_c), .seq_state(st_c), .seq_done(done_c));

    // d: RESET[0] START[1]
    reset_seq_ctrl #(.STARTS(1)) u_d (
        .clk(clk), .reset_n(rn[3]), .restart(rs[3]), .dly_val(dv[3]),
        .reset_cycles(rc[3]), .start_cycles(sc[3]), .step_req(sr[3]),
        .seq_n(seq_d), .seq_state(st_d), .seq_done(done_d));

    // e: RESET[0] STEP[1]
    reset_seq_ctrl #(.STEPS(1)) u_e (
        .clk(clk), .reset_n(rn[4]), .restart(rs[4]), .dly_val(dv[4]),
        .reset_cycles(rc[4]), .start_cycles(sc[4]), .step_req(sr[4]),
        .seq_n(seq_e), .seq_state(st_e), .seq_done(done_e));

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            0:       observe = 16'(seq_a);
            1:       observe = 16'(done_a);
            2:       observe = 16'(st_a);
            3:       observe = 16'(seq_b);
            4:       observe = 16'(done_b);
            5:       observe = 16'(st_b);
            6:       observe = 16'(seq_c);
            7:       observe = 16'(done_c);
            8:       observe = 16'(seq_d);
            9:       observe = 16'(done_d);
            10:      observe = 16'(seq_e);
            11:      observe = 16'(done_e);
            default: observe = 'x;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_total++;
            assert (obs === e.exp) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Instance b reference timeline (reset_cycles=3, start_cycles=2).
    function automatic logic [15:0] exp_b(input int c);
        logic [1:0] r;
        logic       st, cap;
        r   = (c >= 3) ? 2'b11 : 2'b00;
        cap = (c >= 5);
        st  = (c >= 7);
        exp_b = 16'({1'b1, cap, st, r});
    endfunction

    function automatic logic [15:0] state_b(input int c);
        if (c < 3)       state_b = 16'd0;
        else if (c < 5)  state_b = 16'd1;
        else if (c == 5) state_b = 16'd2;
        else if (c == 6) state_b = 16'd3;
        else             state_b = 16'd4;
    endfunction

    initial begin
        logic [11:0] req;
        logic        stp;

        rn = '0; rs = '0; dv = '0; sr = '0;
        rc[0] = 8'd5; sc[0] = 8'd0;
        rc[1] = 8'd3; sc[1] = 8'd2;
        rc[2] = 8'd2; sc[2] = 8'd0; dv[2] = 1'b1;
        rc[3] = 8'd0; sc[3] = 8'd0;
        rc[4] = 8'd1; sc[4] = 8'd1;

        // Reset state of every instance
        tick();
        push("rst_a_seq", 0, 16'd0);  push("rst_a_done", 1, 16'd0);
        push("rst_a_state", 2, 16'd0);
        push("rst_b_seq", 3, 16'd0);  push("rst_b_state", 5, 16'd0);
        push("rst_c_seq", 6, 16'd0);  push("rst_d_seq", 8, 16'd0);
        push("rst_e_seq", 10, 16'd0); push("rst_e_done", 11, 16'd0);
        tick();
        check_all();

        // Defaults, reset_cycles=5
        rn[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            push($sformatf("t1_seq_c%0d", c),   0, 16'(c >= 5));
            push($sformatf("t1_done_c%0d", c),  1, 16'(c >= 5));
            push($sformatf("t1_state_c%0d", c), 2, (c >= 5) ? 16'd4 : 16'd0);
            tick();
            check_all();
        end

        // Full sequence through GAP1, CAPT, GAP2
        rn[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            push($sformatf("t2_seq_c%0d", c),   3, exp_b(c));
            push($sformatf("t2_state_c%0d", c), 5, state_b(c));
            push($sformatf("t2_done_c%0d", c),  4, 16'(c >= 7));
            tick();
            check_all();
        end

        // DELAY latched at start, mid-sequence change ignored
        rn[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) dv[2] = 1'b0;
            push($sformatf("t3_seq_c%0d", c),  6, (c >= 2) ? 16'h1F : 16'h1E);
            push($sformatf("t3_done_c%0d", c), 7, 16'(c >= 2));
            tick();
            check_all();
        end
        rs[2] = 1'b1;
        push("t3_rst_seq", 6, 16'h00); push("t3_rst_done", 7, 16'd0);
        tick(); check_all();
        rs[2] = 1'b0;
        push("t3_hold1_seq", 6, 16'h00);
        tick(); check_all();
        push("t3_end_seq", 6, 16'h01); push("t3_end_done", 7, 16'd1);
        tick(); check_all();

        // Zero durations clamp to one cycle
        rn[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            push($sformatf("t4_seq_c%0d", c), 8,
                 (c == 0) ? 16'd0 : ((c == 1) ? 16'd1 : 16'd3));
            push($sformatf("t4_done_c%0d", c), 9, 16'(c >= 2));
            tick();
            check_all();
        end

        // Restart from DONE, then again during GAP1, then reset with restart
        rs[1] = 1'b1;
        push("t5_rs0_seq", 3, exp_b(0)); push("t5_rs0_state", 5, 16'd0);
        tick(); check_all();
        rs[1] = 1'b0;
        for (int c = 1; c < 4; c++) begin
            push($sformatf("t5a_seq_c%0d", c),   3, exp_b(c));
            push($sformatf("t5a_state_c%0d", c), 5, state_b(c));
            tick();
            check_all();
        end
        rs[1] = 1'b1;
        push("t5_gap1rs_seq", 3, 16'h10); push("t5_gap1rs_state", 5, 16'd0);
        tick(); check_all();
        rs[1] = 1'b0;
        for (int c = 1; c < 9; c++) begin
            push($sformatf("t5b_seq_c%0d", c),   3, exp_b(c));
            push($sformatf("t5b_state_c%0d", c), 5, state_b(c));
            push($sformatf("t5b_done_c%0d", c),  4, 16'(c >= 7));
            tick();
            check_all();
        end
        rn[1] = 1'b0; rs[1] = 1'b1;
        push("t5_rstwin_seq", 3, 16'h00); push("t5_rstwin_state", 5, 16'd0);
        push("t5_rstwin_done", 4, 16'd0);
        tick(); check_all();
        rs[1] = 1'b0;

        // STEP behaviour (pulse build or level build)
        req = 12'b0000_0111_0101;
        rn[4] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            sr[4] = req[c];
            stp = c_PULSE ? ((c >= 3) && req[c]) : (c >= 2);
            push($sformatf("t6_seq_c%0d", c),  10, 16'({stp, (c >= 1)}));
            push($sformatf("t6_done_c%0d", c), 11, 16'(c >= 2));
            tick();
            check_all();
        end
        sr[4] = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_seq_ctrl.md
Name: reset_seq_ctrl

Overview:
- Synthesizable, clocked successor to the behavioural reset/start generator used in CSP-to-Verilog testbenches and emitted wrappers.
- Drives a concatenated bus of active-low control groups: RESET, START, STEP, DELAY, CAPTURE, CUTSCAN, PASSTHRU, INJECT.
- Sequence durations are counted in cycles, programmable at run time, and the sequence is re-triggerable without a global reset.

Parameters:
- RESETS, 1, width of RESET group.
- STARTS, 0, width of START group.
- STEPS, 0, width of STEP group.
- DELAYS, 0, width of DELAY group.
- CAPTURES, 0, width of CAPTURE group.
- CUTSCANS, 0, width of CUTSCAN group.
- PASSTHRUS, 0, width of PASSTHRU group.
- INJECTS, 0, width of INJECT group.
- CNT_W, 8, width of the duration counter and duration inputs.
- N (localparam), the sum of all group widths; must be at least 1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- restart  in  1  single-cycle request to re-run the sequence from HOLD.
- dly_val  in  1  value driven on all DELAY bits; sampled at sequence start.
- reset_cycles  in  CNT_W  HOLD duration; sampled at sequence start.
- start_cycles  in  CNT_W  duration of each gap stage; sampled at sequence start.
- step_req  in  1  step pulse request (used only with the optional feature).
- seq_n  out  N  control bus. Group offsets in order: RESET at 0, then START, STEP, DELAY, CAPTURE, CUTSCAN, PASSTHRU, INJECT.
- seq_state  out  3  current FSM state encoding.
- seq_done  out  1  high while in DONE.

Behaviour:
Interface rule:
- One clock, clk. Reset is reset_n: synchronous and active-low. All state updates occur on the rising edge of clk.

While reset_n=0:
- FSM goes to HOLD and all seq_n bits are 0.
- Duration registers load reset_cycles and start_cycles; the DELAY value loads dly_val.
- Counter is cleared; seq_done=0.

FSM states: HOLD, GAP1, CAPT, GAP2, DONE.
- HOLD: PASSTHRU=1 and DELAY=latched dly_val; every other bit is 0. Stays for max(reset_cycles,1) cycles, counted from the first cycle after reset_n rises. Then RESET bits go to 1 on the next edge.
  - If STARTS+STEPS+CAPTURES>0, go to GAP1. Otherwise go to DONE.
- GAP1: lasts max(start_cycles,1) cycles.
  - If CAPTURES>0, go to CAPT.
  - Otherwise go to DONE.
- CAPT: CAPTURE bits=1 on entry.
  - If STARTS+STEPS>0, go to GAP2, which lasts max(start_cycles,1) cycles, then DONE.
  - Otherwise go directly to DONE.
- DONE: START=1 and STEP=1. seq_done=1. State is held until restart or reset.

Fixed outputs:
- CUTSCAN and INJECT bits stay 0 in every state.

Duration and counter rules:
- A duration value of 0 is treated as 1.
- The counter counts down from the loaded value. It saturates at 0 and never wraps.

restart:
- restart=1 in any state: on the next edge go to HOLD and apply HOLD outputs. Reload durations and DELAY from the inputs.
- restart during HOLD restarts the HOLD count.
- If reset_n=0 and restart=1 together, reset wins.

Other input rules:
- Changes on the duration inputs or dly_val mid-sequence have no effect until the next restart or reset.
- All outputs are registered. Output latency from a state change is 0 cycles after the edge.

Optional Feature:
Macro: RESET_SEQ_CTRL_STEP_PULSE_EN
- Defined: in DONE, STEP bits are 0 by default. Each cycle with step_req=1 sampled in DONE produces STEP=1 for exactly one cycle on the next edge. Back-to-back requests give continuous 1s. step_req outside DONE is ignored.
- Undefined: STEP bits behave exactly like START bits, and step_req is unused.

Decomposition:
- Package reset_seq_pkg:
  - seq_state_e enum: HOLD=0, GAP1=1, CAPT=2, GAP2=3, DONE=4.
  - Function computing group begin offsets from the width parameters.
- One sub-module, seq_dur_counter: loadable saturating down-counter with zero-to-one clamp. Outputs expire when the count reaches 1.
- Top level holds the FSM and the per-group output mux.

Test Plan:
1. Defaults (RESETS=1), reset_cycles=5: reset_n rises at cycle 0. seq_n=0 for cycles 0–4, seq_n=1 from cycle 5, seq_done=1 at cycle 5.
2. RESETS=2, STARTS=1, CAPTURES=1, PASSTHRUS=1, reset_cycles=3, start_cycles=2:
   - PASSTHRU=1 from reset.
   - RESET=11 at cycle 3.
   - CAPTURE=1 at cycle 5.
   - START=1 at cycle 7; seq_done=1.
3. DELAYS=4, dly_val=1 at reset: DELAY=4'b1111 throughout. Change dly_val to 0 mid-sequence: no change. Pulse restart: DELAY=0000 on the next edge.
4. reset_cycles=0, start_cycles=0, STARTS=1: RESET=1 after 1 cycle and START=1 after 1 more cycle. No wrap to a 256-cycle wait.
5. restart asserted during GAP1: next edge gives HOLD. RESET and START are 0, PASSTHRU stays 1, and the full sequence re-runs. Assert reset_n=0 together with restart: all bits 0.
6. With RESET_SEQ_CTRL_STEP_PULSE_EN, STEPS=1: in DONE, step_req high for 1 cycle gives a single STEP pulse. Held 3 cycles gives STEP high for 3 cycles. Before DONE, step_req gives no pulse.
